// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto a single-ported unified memory
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    input  logic        if_kill,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        RSP_IF = 2'd1,
        RSP_D  = 2'd2
    } rsp_state_t;

    rsp_state_t rsp_state;
    logic [3:0] starve_cnt;
    logic       fetch_pri;
    logic       d_load_gnt;

    // Fetch overrides data only once it has been denied long enough.
    assign fetch_pri  = if_req && (starve_cnt == STARVE_LIM);
    assign d_gnt      = rst_n && d_req && !fetch_pri;
    assign if_gnt     = rst_n && if_req && (fetch_pri || !d_req);
    assign d_load_gnt = d_gnt && !d_we;

    always_comb begin
        mem_en    = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (d_gnt) begin
            mem_be    = d_we ? d_be : 4'hF;
            mem_addr  = d_addr & ~32'h3;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_be    = 4'hF;
            mem_addr  = if_addr & ~32'h3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_state  <= NONE;
            starve_cnt <= 4'd0;
        end else begin
            if (if_gnt)
                rsp_state <= RSP_IF;
            else if (d_load_gnt)
                rsp_state <= RSP_D;
            else
                rsp_state <= NONE;

            if (!if_req || if_gnt)
                starve_cnt <= 4'd0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // A flush only hides the pending fetch beat; the FSM still tracks new grants.
    assign if_rvalid = (rsp_state == RSP_IF) && !if_kill;
    assign d_rvalid  = (rsp_state == RSP_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_kill, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];
    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_kill(if_kill),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[15:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[15:2]];
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (if_rvalid) begin
                checks++;
                if (exp_if.size() == 0) begin
                    errors++;
                    $display("FAIL if_unexpected_rvalid: got if_rvalid=1 rdata=%h, expected none", if_rdata);
                end else begin
                    logic [31:0] e;
                    e = exp_if.pop_front();
                    if (if_rdata !== e) begin
                        errors++;
                        $display("FAIL if_rdata: got %h expected %h", if_rdata, e);
                    end
                end
            end
            if (d_rvalid) begin
                checks++;
                if (exp_d.size() == 0) begin
                    errors++;
                    $display("FAIL d_unexpected_rvalid: got d_rvalid=1 rdata=%h, expected none", d_rdata);
                end else begin
                    logic [31:0] e;
                    e = exp_d.pop_front();
                    if (d_rdata !== e) begin
                        errors++;
                        $display("FAIL d_rdata: got %h expected %h", d_rdata, e);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0; if_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h100; d_addr = 32'h5000;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({if_gnt, d_gnt, mem_en, mem_we, mem_be, if_rvalid, d_rvalid} !== 10'b0) begin
                errors++;
                $display("FAIL reset_outputs: got gnt=%b%b en=%b we=%b be=%h rv=%b%b, expected all 0",
                         if_gnt, d_gnt, mem_en, mem_we, mem_be, if_rvalid, d_rvalid);
            end
        end
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b0 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset: got mem_en=%b rv=%b%b expected 0", mem_en, if_rvalid, d_rvalid);
            end
            next_cycle();
        end
    endtask

    task automatic test_fetch_read();
        if_req = 1'b1; if_addr = 32'h103;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
            mem_be !== 4'hF || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL fetch_grant: got gnt=%b%b en=%b we=%b be=%h addr=%h expected 10 1 0 f 00000100",
                     if_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr);
        end
        exp_if.push_back(32'hDEADBEEF);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL fetch_rvalid: got if_rvalid=%b mem_en=%b expected 1 0", if_rvalid, mem_en);
        end
        next_cycle();
    endtask

    task automatic test_store_load();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 32'h5000; d_wdata = 32'h0000AB00;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0010 ||
            mem_addr !== 32'h5000 || mem_wdata !== 32'h0000AB00) begin
            errors++;
            $display("FAIL store_drive: got gnt=%b we=%b be=%b addr=%h wdata=%h expected 1 1 0010 00005000 0000ab00",
                     d_gnt, mem_we, mem_be, mem_addr, mem_wdata);
        end
        next_cycle();
        d_we = 1'b0; d_be = 4'h0; d_addr = 32'h5002;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'hF || mem_addr !== 32'h5000) begin
            errors++;
            $display("FAIL load_drive: got rvalid=%b gnt=%b we=%b be=%h addr=%h expected 0 1 0 f 00005000",
                     d_rvalid, d_gnt, mem_we, mem_be, mem_addr);
        end
        exp_d.push_back(32'h1122AB44);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL load_rvalid: got %b expected 1", d_rvalid);
        end
        next_cycle();
    endtask

    task automatic run_contention(input int ncyc, input string tag);
        logic prev_if;
        prev_if = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        for (int i = 0; i < ncyc; i++) begin
            logic want_if;
            want_if = (i % 5) == 4;
            @(negedge clk);
            checks++;
            if (if_gnt !== want_if || d_gnt !== !want_if || if_rvalid !== prev_if) begin
                errors++;
                $display("FAIL %s_cycle%0d: got if_gnt=%b d_gnt=%b if_rvalid=%b expected %b %b %b",
                         tag, i, if_gnt, d_gnt, if_rvalid, want_if, !want_if, prev_if);
            end
            if (want_if) exp_if.push_back(32'hDEADBEEF);
            else         exp_d.push_back(32'h1122AB44);
            prev_if = want_if;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_starvation();
        run_contention(15, "starve");
    endtask

    task automatic test_kill();
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL kill_first_gnt: got %b expected 1", if_gnt);
        end
        next_cycle();
        if_kill = 1'b1; if_addr = 32'h104;
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0 || if_gnt !== 1'b1) begin
            errors++;
            $display("FAIL kill_cycle: got if_rvalid=%b if_gnt=%b expected 0 1", if_rvalid, if_gnt);
        end
        exp_if.push_back(32'hCAFEF00D);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL kill_next_rvalid: got %b expected 1", if_rvalid);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_load_gnt: got d_gnt=%b if_gnt=%b expected 1 0", d_gnt, if_gnt);
        end
        #1 rst_n = 1'b0;
        repeat (3) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if ({d_rvalid, if_rvalid, d_gnt, if_gnt, mem_en} !== 5'b0) begin
                errors++;
                $display("FAIL midrst_held: got rv=%b%b gnt=%b%b en=%b expected 0",
                         d_rvalid, if_rvalid, d_gnt, if_gnt, mem_en);
            end
        end
        next_cycle();
        rst_n = 1'b1;
        run_contention(5, "postrst");
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[14'h0040] = 32'hDEADBEEF;
        mem[14'h0041] = 32'hCAFEF00D;
        mem[14'h1400] = 32'h11223344;
        idle_inputs();
        test_reset();
        test_fetch_read();
        test_store_load();
        test_starvation();
        test_kill();
        test_reset_mid_read();
        repeat (2) next_cycle();
        checks++;
        if (exp_if.size() != 0 || exp_d.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d fetch and %0d data responses outstanding, expected 0",
                     exp_if.size(), exp_d.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the pipeline's instruction-fetch port and data (load/store) port onto the single-ported, byte-addressed unified memory inside `top`. Each cycle it grants at most one requester and drives the memory. It then routes the one-cycle-latency read data back to whichever port owns it. Data has priority over fetch, but a starvation counter guarantees fetch progress. A flush input discards an in-flight fetch response.

## Interface
Parameters:
- `STARVE_MAX`, 4: consecutive denied fetch-request cycles after which fetch takes priority; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request.
- `if_addr`  in  32  fetch byte address; bits [1:0] are ignored.
- `if_gnt`  out  1  fetch request accepted this cycle (combinational).
- `if_kill`  in  1  flush; suppresses a fetch response due this cycle.
- `if_rvalid`  out  1  fetch read data valid (registered).
- `if_rdata`  out  32  fetch read data.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  4  byte enables for stores; ignored for loads.
- `d_addr`  in  32  data byte address; bits [1:0] are ignored (the core pre-aligns and encodes lanes in `d_be`).
- `d_wdata`  in  32  store data, lane-aligned.
- `d_gnt`  out  1  data request accepted this cycle (combinational).
- `d_rvalid`  out  1  load data valid (registered); never asserted for stores.
- `d_rdata`  out  32  load data.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write.
- `mem_be`  out  4  memory byte enables.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid the cycle after a read `mem_en`.

## Operation
- Grant rule, evaluated each cycle:
  - If `starve_cnt == STARVE_MAX` and `if_req` is high, fetch wins.
  - Otherwise, if `d_req` is high, data wins.
  - Otherwise, if `if_req` is high, fetch wins.
  - Exactly one of `if_gnt`/`d_gnt` is high when any request is present; both are low otherwise.
- Memory drive follows the winner:
  - `mem_en = if_gnt | d_gnt`.
  - `mem_we = d_gnt & d_we`.
  - `mem_be` = `d_be` on a data store, `4'hF` on any read.
  - When `mem_en` = 0: address and data are don't-care, `mem_we` = 0 and `mem_be` = 0.
- Response FSM `rsp_state` ∈ {NONE, RSP_IF, RSP_D}, updated every edge:
  - Fetch granted → RSP_IF.
  - Data load granted → RSP_D.
  - Data store granted, or no grant → NONE.
  - Back-to-back grants are allowed with no bubble.
- Response outputs:
  - `if_rvalid = (rsp_state==RSP_IF) & ~if_kill`.
  - `d_rvalid = (rsp_state==RSP_D)`.
  - `if_rdata` and `d_rdata` both mirror `mem_rdata` unconditionally; consumers qualify with rvalid.
  - `if_rvalid` and `d_rvalid` are registered-state-derived, except for the `if_kill` gating.
- Starvation counter `starve_cnt`, 4 bits:
  - Increments when `if_req & ~if_gnt`, saturating at `STARVE_MAX`.
  - Clears to 0 on `if_gnt` or when `if_req` is low.
- `if_kill` does not block a new fetch grant in the same cycle; the new request's response arrives normally next cycle.

## Timing
- Reset values (asynchronous): `rsp_state` = NONE, `starve_cnt` = 0. While `rst_n` is low, `if_gnt`, `d_gnt`, `mem_en`, `mem_we` and `mem_be` are forced to 0, regardless of requests.
- Read latency: grant in cycle N → rvalid and valid rdata in cycle N+1.
- Stores complete in the grant cycle; they produce no response.
- Throughput: one access per cycle.
- Under continuous `d_req` and `if_req`, fetch is granted once every `STARVE_MAX+1` cycles.
- Reset asserted mid-operation: a pending response is dropped, no rvalid follows, and the counter clears.
- After `rst_n` deasserts, the first edge may grant.
- Simultaneous `if_kill` and a pending RSP_IF: the response is suppressed and the FSM still advances per that cycle's grant.

## Test plan
- Reset and idle: hold `rst_n`=0 with both reqs high → all gnt, `mem_en` and rvalid are 0. Release reset with no reqs → `mem_en` stays 0.
- Fetch read: `if_req`=1, `if_addr`=0x103, memory word at 0x100 = 0xDEADBEEF → `if_gnt`=1 and `mem_addr`=0x100 in cycle N; `if_rvalid`=1 and `if_rdata`=0xDEADBEEF in N+1.
- Store then load: `d_we`=1, `d_be`=4'b0010, `d_addr`=0x5000, `d_wdata`=0x0000AB00 → `mem_we`=1, `mem_be`=0010, no `d_rvalid`. A following load of 0x5000 → `d_rvalid` in the next cycle, with byte 1 = 0xAB.
- Priority and starvation, `STARVE_MAX`=4: both reqs held high continuously → `d_gnt` for 4 cycles, then `if_gnt` for 1 cycle, repeating. Fetch rvalid appears the cycle after each `if_gnt`.
- Kill: fetch granted in cycle N, `if_kill`=1 in N+1 with a new fetch request → `if_rvalid`=0 in N+1; `if_gnt`=1 in N+1; `if_rvalid`=1 in N+2.
- Reset mid-read: load granted, then `rst_n`=0 before the next edge → `d_rvalid` never asserts, and `starve_cnt` reads 0 after reset.
